ack_bus_arbiter: RTL

//   Parametrised arbiter for the shared acknowledge bus between the crypto engines (mem, sha, aes, ctrl, ...).

---
 rtl/ack_bus_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ack_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ack_bus_arbiter
//
// Arbiter for the shared acknowledge bus between the crypto engines.
// Sources raise level requests. In IDLE one winner is picked per
// arbitration, using either fixed priority (lowest index wins) or
// round-robin. The winner then owns the active-low bus for HOLD_CYC cycles.
// A bus-released IDLE cycle always follows, so back-to-back grants are
// spaced HOLD_CYC+1 cycles apart.
//
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   rr_mode_i          in   1 = round-robin, 0 = fixed priority
//   req_i              in   [N_SRC-1:0] level request per source
//   ack_ready_o        out  [N_SRC-1:0] one-hot ready pulse to the winner
//   winner_id_o        out  [ID_W-1:0]  most recent winner, held
//   ack_event_o        out  one-cycle pulse on each grant
//   ack_valid_n_bus_o  out  active-low bus valid
//   ack_id_bus_o       out  [ID_W-1:0]  winner ID while bus valid, else 0
//   busy_o             out  high whenever the FSM is not IDLE
//   ack_cnt_o          out  [CNT_W-1:0] saturating count of grants
//
// Every output comes straight from a flop, so there is no combinational
// path from req_i or rr_mode_i to any output.
// ---------------------------------------------------------------------------
module ack_bus_arbiter #(
    parameter int N_SRC    = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rr_mode_i,
    input  logic [N_SRC-1:0] req_i,
    output logic [N_SRC-1:0] ack_ready_o,
    output logic [ID_W-1:0]  winner_id_o,
    output logic             ack_event_o,
    output logic             ack_valid_n_bus_o,
    output logic [ID_W-1:0]  ack_id_bus_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] ack_cnt_o
);

    // Parameter sanity checks, raised at elaboration time.
    generate
        if ((N_SRC < 2) || (N_SRC > 16)) begin : g_bad_n_src
            $error("ack_bus_arbiter: N_SRC must be in 2..16");
        end
        if ((2 ** ID_W) < N_SRC) begin : g_bad_id_w
            $error("ack_bus_arbiter: ID_W too narrow for N_SRC");
        end
        if (HOLD_CYC < 1) begin : g_bad_hold
            $error("ack_bus_arbiter: HOLD_CYC must be >= 1");
        end
    endgenerate

    // The hold counter only has to hold HOLD_CYC-1.
    localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Saturating increment for the grant counter: it sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state, state_nxt;
    logic [HC_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [N_SRC-1:0] ack_ready_nxt;
    logic [ID_W-1:0]  winner_id_nxt;
    logic             ack_event_nxt;
    logic             bus_valid_n_nxt;
    logic [ID_W-1:0]  bus_id_nxt;
    logic             busy_nxt;
    logic [CNT_W-1:0] ack_cnt_nxt;

    // Winner search. Fixed priority is the round-robin search started at 0,
    // so one scan serves both modes. The pointer keeps advancing in fixed
    // mode too, so a later switch to round-robin resumes after the last winner.
    logic             sel_found;
    logic [ID_W-1:0]  sel_id;
    int               start;
    int               idx;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        start     = rr_mode_i ? int'(ptr) : 0;
        idx       = 0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = start + i;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!sel_found && req_i[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    // Next-state and next-output logic. Registered outputs keep their value
    // unless a transition changes them. The ready and event pulses default to
    // zero, which limits them to the first DRIVE cycle.
    always_comb begin
        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        ptr_nxt         = ptr;
        ack_ready_nxt   = '0;
        ack_event_nxt   = 1'b0;
        winner_id_nxt   = winner_id_o;
        bus_valid_n_nxt = ack_valid_n_bus_o;
        bus_id_nxt      = ack_id_bus_o;
        busy_nxt        = busy_o;
        ack_cnt_nxt     = ack_cnt_o;

        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt       = DRIVE;
                    hold_cnt_nxt    = HC_W'(HOLD_CYC - 1);
                    ptr_nxt         = (sel_id == ID_W'(N_SRC - 1)) ? '0
                                                                   : sel_id + ID_W'(1);
                    ack_ready_nxt   = N_SRC'(1) << sel_id;
                    ack_event_nxt   = 1'b1;
                    winner_id_nxt   = sel_id;
                    bus_valid_n_nxt = 1'b0;
                    bus_id_nxt      = sel_id;
                    busy_nxt        = 1'b1;
                    ack_cnt_nxt     = sat_inc(ack_cnt_o);
                end
            end
            DRIVE: begin
                // req_i is deliberately not looked at here. The IDLE cycle
                // that follows guarantees the bus is released between acks.
                if (hold_cnt == '0) begin
                    state_nxt       = IDLE;
                    bus_valid_n_nxt = 1'b1;
                    bus_id_nxt      = '0;
                    busy_nxt        = 1'b0;
                end else begin
                    hold_cnt_nxt = hold_cnt - HC_W'(1);
                end
            end
            default: begin
                state_nxt       = IDLE;
                bus_valid_n_nxt = 1'b1;
                bus_id_nxt      = '0;
                busy_nxt        = 1'b0;
            end
        endcase
    end

    // State and output registers. An asynchronous reset releases the bus
    // immediately, even in the middle of a DRIVE window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            hold_cnt          <= '0;
            ptr               <= '0;
            ack_ready_o       <= '0;
            ack_event_o       <= 1'b0;
            winner_id_o       <= '0;
            ack_valid_n_bus_o <= 1'b1;
            ack_id_bus_o      <= '0;
            busy_o            <= 1'b0;
            ack_cnt_o         <= '0;
        end else begin
            state             <= state_nxt;
            hold_cnt          <= hold_cnt_nxt;
            ptr               <= ptr_nxt;
            ack_ready_o       <= ack_ready_nxt;
            ack_event_o       <= ack_event_nxt;
            winner_id_o       <= winner_id_nxt;
            ack_valid_n_bus_o <= bus_valid_n_nxt;
            ack_id_bus_o      <= bus_id_nxt;
            busy_o            <= busy_nxt;
            ack_cnt_o         <= ack_cnt_nxt;
        end
    end

endmodule
